zbus_wr_capture: RTL and testbench

Captures Z80 write cycles from the asynchronous ZX-BUS pins into the 50 MHz FPGA domain and queues them for downstream register files (video, audio, SRAM window). Sits directly behind the multiplexed-address capture: it demultiplexes `fa` by `fa_sel` into a 16-bit address, qualifies IO-write and MEM-write strobes, and pushes `{type, addr, data}` entries into a small FIFO. The FIFO is drained through a valid/ready handshake.

---
 rtl/zbus_pkg.sv | 44 ++++
 rtl/zbus_fifo.sv | 50 +++++
 rtl/zbus_wr_capture.sv | 147 ++++++++++++++
 tb/tb_zbus_wr_capture.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/zbus_pkg.sv
// Shared types for the ZX-BUS write capture path.
package zbus_pkg;

    // Kind of captured bus write
    typedef enum logic {
        ZB_IO  = 1'b0,
        ZB_MEM = 1'b1
    } zbus_type_t;

    // One queued write, 25 bits: {type, addr, data}
    typedef struct packed {
        zbus_type_t  wtype;
        logic [15:0] addr;
        logic [7:0]  data;
    } zbus_entry_t;

    // Bundle of every asynchronous bus input, synchronized as one word
    typedef struct packed {
        logic [7:0] fa;
        logic       fa_sel;
        logic [7:0] fd;
        logic       iorq_n;
        logic       mrq_n;
        logic       wr_n;
        logic       m1_n;
    } zbus_pins_t;

    // Idle bus: strobes deasserted, address/data zero
    localparam zbus_pins_t PINS_IDLE = '{
        fa:     8'h00,
        fa_sel: 1'b0,
        fd:     8'h00,
        iorq_n: 1'b1,
        mrq_n:  1'b1,
        wr_n:   1'b1,
        m1_n:   1'b1
    };

    // Saturating 8-bit increment
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/zbus_fifo.sv
// Synchronous FIFO of zbus_entry_t; extra pointer bit separates full from empty.
module zbus_fifo
    import zbus_pkg::*;
#(
    parameter int unsigned DEPTH = 8
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  zbus_entry_t wr_data,
    input  logic        rd_en,
    output zbus_entry_t rd_data,
    output logic        empty,
    output logic        full
);

    localparam int unsigned AW = $clog2(DEPTH);

    zbus_entry_t mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_wr;
    logic        do_rd;

    // Status flags and accepted read/write; a write while full is allowed when a read frees the slot
    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        do_rd   = rd_en && !empty;
        do_wr   = wr_en && (!full || do_rd);
        rd_data = mem[rd_ptr[AW-1:0]];
    end

    // Pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/zbus_wr_capture.sv
// Captures Z80 IO/MEM write cycles from the async ZX-BUS into a FIFO in the CLK50 domain.
module zbus_wr_capture
    import zbus_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned SYNC  = 2
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  fa,
    input  logic        fa_sel,
    input  logic [7:0]  fd,
    input  logic        fiorq_n,
    input  logic        fmrq_n,
    input  logic        fwr_n,
    input  logic        fm1_n,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_type,
    output logic [15:0] out_addr,
    output logic [7:0]  out_data,
    output logic        ovf,
    output logic [7:0]  drop_cnt,
    input  logic        ovf_clr
);

    zbus_pins_t  pins_in;
    zbus_pins_t  pins_s;
    zbus_pins_t  sync_q [SYNC];
    logic [SYNC-1:0] arm_sr;
    logic        armed;
    logic [15:0] zaddr;
    logic        raw_io, raw_mem, raw_io_d, raw_mem_d;
    logic        qual_io, qual_mem, qual_io_q, qual_mem_q;
    logic        push_io, push_mem, push;
    logic        push_q;
    zbus_entry_t push_entry;
    zbus_entry_t head;
    logic        fifo_empty, fifo_full;
    logic        pop, drop;

    // Pack the pins into one word so every bit sees the same synchronizer depth
    always_comb begin
        pins_in = '{fa: fa, fa_sel: fa_sel, fd: fd, iorq_n: fiorq_n,
                    mrq_n: fmrq_n, wr_n: fwr_n, m1_n: fm1_n};
        pins_s  = sync_q[SYNC-1];
    end

    // Synchronizer chain, resets to an idle bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SYNC; i++) sync_q[i] <= PINS_IDLE;
        end else begin
            sync_q[0] <= pins_in;
            for (int unsigned i = 1; i < SYNC; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // Address demux from the synchronized multiplexed bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               zaddr       <= '0;
        else if (pins_s.fa_sel)   zaddr[15:8] <= pins_s.fa;
        else                      zaddr[7:0]  <= pins_s.fa;
    end

    // Raw conditions, two-sample qualification and rising-edge push (IO beats MEM)
    always_comb begin
        raw_io   = !pins_s.iorq_n && !pins_s.wr_n && pins_s.m1_n;
        raw_mem  = !pins_s.mrq_n  && !pins_s.wr_n;
        qual_io  = raw_io  && raw_io_d;
        qual_mem = raw_mem && raw_mem_d;
        push_io  = qual_io  && !qual_io_q;
        push_mem = qual_mem && !qual_mem_q && !qual_io;
        push     = armed && (push_io || push_mem);
    end

    // Arming: after reset the chain must refill with real pins and see the bus idle once,
    // so a strobe held low across reset release never produces a push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_sr <= '0;
            armed  <= 1'b0;
        end else begin
            arm_sr <= {arm_sr[SYNC-2:0], 1'b1};
            if (arm_sr[SYNC-1] && !raw_io && !raw_mem) armed <= 1'b1;
        end
    end

    // Qualifier history and registered push entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_io_d   <= 1'b0;
            raw_mem_d  <= 1'b0;
            qual_io_q  <= 1'b0;
            qual_mem_q <= 1'b0;
            push_q     <= 1'b0;
            push_entry <= '0;
        end else begin
            raw_io_d   <= raw_io;
            raw_mem_d  <= raw_mem;
            qual_io_q  <= qual_io;
            qual_mem_q <= qual_mem;
            push_q     <= push;
            if (push) begin
                push_entry <= '{wtype: (push_io ? ZB_IO : ZB_MEM),
                                addr:  zaddr,
                                data:  pins_s.fd};
            end
        end
    end

    zbus_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push_q),
        .wr_data (push_entry),
        .rd_en   (pop),
        .rd_data (head),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // Handshake and output view; head is forced to zero when empty
    always_comb begin
        out_valid = !fifo_empty;
        pop       = out_valid && out_ready;
        drop      = push_q && fifo_full && !pop;
        out_type  = out_valid ? head.wtype : 1'b0;
        out_addr  = out_valid ? head.addr  : 16'h0000;
        out_data  = out_valid ? head.data  : 8'h00;
    end

    // Overflow flag and saturating drop counter; a drop outranks a clear in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            ovf      <= 1'b1;
            drop_cnt <= ovf_clr ? 8'd1 : sat_inc8(drop_cnt);
        end else if (ovf_clr) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_zbus_wr_capture.sv
// Directed scoreboard bench for zbus_wr_capture (DEPTH=8, SYNC=2).
module tb_zbus_wr_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  fa;
    logic        fa_sel;
    logic [7:0]  fd;
    logic        fiorq_n, fmrq_n, fwr_n, fm1_n;
    logic        out_valid;
    logic        out_ready;
    logic        out_type;
    logic [15:0] out_addr;
    logic [7:0]  out_data;
    logic        ovf;
    logic [7:0]  drop_cnt;
    logic        ovf_clr;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [24:0] exp_q [$];

    zbus_wr_capture #(.DEPTH(8), .SYNC(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fa        (fa),
        .fa_sel    (fa_sel),
        .fd        (fd),
        .fiorq_n   (fiorq_n),
        .fmrq_n    (fmrq_n),
        .fwr_n     (fwr_n),
        .fm1_n     (fm1_n),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_type  (out_type),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .ovf       (ovf),
        .drop_cnt  (drop_cnt),
        .ovf_clr   (ovf_clr)
    );

    // 50 MHz
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [24:0] head_now();
        return {out_type, out_addr, out_data};
    endfunction

    task automatic setup_addr(input logic [15:0] addr);
        @(negedge clk);
        fa_sel = 1'b1; fa = addr[15:8];
        repeat (3) @(negedge clk);
        fa_sel = 1'b0; fa = addr[7:0];
        repeat (3) @(negedge clk);
    endtask

    // Drops the strobes on the current negedge
    task automatic strobe_on(input logic kind, input logic [7:0] data);
        fd    = data;
        fm1_n = 1'b1;
        fwr_n = 1'b0;
        if (kind) fmrq_n = 1'b0; else fiorq_n = 1'b0;
    endtask

    task automatic strobe_off();
        fwr_n = 1'b1; fiorq_n = 1'b1; fmrq_n = 1'b1;
    endtask

    // Full 300 ns write cycle; the expected entry is queued as stimulus is driven
    task automatic bus_write(input logic kind, input logic [15:0] addr, input logic [7:0] data,
                             input bit expect_push);
        setup_addr(addr);
        strobe_on(kind, data);
        if (expect_push) exp_q.push_back({kind, addr, data});
        repeat (15) @(negedge clk);
        strobe_off();
        repeat (4) @(negedge clk);
    endtask

    // Accept entries until the scoreboard is empty, comparing each head as it is taken
    task automatic drain(input string tag);
        int unsigned guard = 0;
        logic [24:0] e;
        @(negedge clk);
        out_ready = 1'b1;
        while (exp_q.size() > 0 && guard < 100) begin
            if (out_valid) begin
                e = exp_q.pop_front();
                chk(tag, {7'd0, head_now()}, {7'd0, e});
            end
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk({tag, "_timeout"}, exp_q.size(), 0);
        out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_empty"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        logic [24:0] e;
        rst_n = 1'b0; fa = '0; fa_sel = 1'b0; fd = '0;
        fiorq_n = 1'b1; fmrq_n = 1'b1; fwr_n = 1'b1; fm1_n = 1'b1;
        out_ready = 1'b0; ovf_clr = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_head",  {7'd0, head_now()}, 32'd0);
        chk("rst_ovf",   {31'd0, ovf}, 32'd0);
        chk("rst_drop",  {24'd0, drop_cnt}, 32'd0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // IO write 0x00FE <- 0x07, out_valid rises on the 5th edge after WR falls
        setup_addr(16'h00FE);
        strobe_on(1'b0, 8'h07);
        exp_q.push_back({1'b0, 16'h00FE, 8'h07});
        repeat (4) @(negedge clk);
        chk("lat_edge4", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_edge5", {31'd0, out_valid}, 32'd1);
        repeat (10) @(negedge clk);
        strobe_off();
        repeat (4) @(negedge clk);
        drain("io_fe");

        // MEM then IO, held with out_ready low, then drained in order
        bus_write(1'b1, 16'hC000, 8'h55, 1'b1);
        bus_write(1'b0, 16'h7FFD, 8'h10, 1'b1);
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_head",  {7'd0, head_now()}, {7'd0, exp_q[0]});
        drain("mem_io");

        // Interrupt acknowledge and a one-sample WR glitch produce nothing
        @(negedge clk);
        fiorq_n = 1'b0; fm1_n = 1'b0;
        repeat (15) @(negedge clk);
        fiorq_n = 1'b1; fm1_n = 1'b1;
        repeat (4) @(negedge clk);
        fmrq_n = 1'b0; fwr_n = 1'b0;
        @(negedge clk);
        fmrq_n = 1'b1; fwr_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("no_entry", {31'd0, out_valid}, 32'd0);

        // Ten IO writes into an 8-deep FIFO: two dropped
        for (int i = 0; i < 10; i++)
            bus_write(1'b0, 16'h1000 + 16'(i), 8'hA0 + 8'(i), (i < 8));
        chk("ovf_set",  {31'd0, ovf}, 32'd1);
        chk("drop_two", {24'd0, drop_cnt}, 32'd2);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        @(negedge clk);
        chk("ovf_clr",  {31'd0, ovf}, 32'd0);
        chk("drop_clr", {24'd0, drop_cnt}, 32'd0);

        // Full FIFO: push and pop land on the same edge
        setup_addr(16'h2345);
        strobe_on(1'b1, 8'h99);
        exp_q.push_back({1'b1, 16'h2345, 8'h99});
        repeat (4) @(negedge clk);
        e = exp_q.pop_front();
        chk("full_head", {7'd0, head_now()}, {7'd0, e});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("full_advance", {7'd0, head_now()}, {7'd0, exp_q[0]});
        chk("full_nodrop",  {24'd0, drop_cnt}, 32'd0);
        chk("full_noovf",   {31'd0, ovf}, 32'd0);
        repeat (10) @(negedge clk);
        strobe_off();
        repeat (4) @(negedge clk);
        drain("full_pp");

        // Reset mid-strobe with three entries queued
        for (int i = 0; i < 3; i++)
            bus_write(1'b0, 16'h3300 + 16'(i), 8'h30 + 8'(i), 1'b1);
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        setup_addr(16'h4444);
        strobe_on(1'b0, 8'h44);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", {31'd0, out_valid}, 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("rst_held_strobe", {31'd0, out_valid}, 32'd0);
        strobe_off();
        repeat (5) @(negedge clk);
        chk("rst_still_empty", {31'd0, out_valid}, 32'd0);
        bus_write(1'b0, 16'h5566, 8'h77, 1'b1);
        drain("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time limit
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
